// File: rtl/pixel_shifter_pkg.sv
// Shared definitions for the pixel shifter: FSM encoding and frame constants.
package pixel_shifter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StShift,
    StLatch
  } state_e;

  localparam int unsigned BITS_PER_PIXEL       = 24;
  localparam int unsigned DEFAULT_RESET_CYCLES = 1500;

endpackage

// File: rtl/pixel_shifter_latch_timer.sv
// Strip latch timer: held at zero while load is high, then counts up to CYCLES-1 and stops.
module pixel_shifter_latch_timer
  import pixel_shifter_pkg::*;
#(
  parameter int unsigned CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic done
);

  localparam int unsigned CntW = $clog2(CYCLES + 1);

  logic [CntW-1:0] count_q;

  assign done = (count_q == CntW'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn || load) begin
      count_q <= '0;
    end else if (!done) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/pixel_shifter.sv
// Serialises 24-bit GRB pixels MSB-first on request, then holds the strip latch period.
module pixel_shifter
  import pixel_shifter_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_start,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [7:0]  pixel_index,
  input  logic        new_bit_rqst,
  output logic        bit_to_transmit,
  output logic        all_bits_shifted,
  output logic        reset_finish,
  output logic        busy,
  output logic        underrun
);

  localparam logic [7:0] NumLeds = 8'(NUM_LEDS);
  localparam logic [4:0] TopBit  = 5'(BITS_PER_PIXEL - 1);

  state_e                    state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] hold_q, shift_q, load_word;
  logic                      hold_full_q, hold_full_d;
  logic [4:0]                bit_cnt_q;
  logic [7:0]                accepted_q, accepted_d, shifted_q;
  logic                      ready_q, ready_d, latch_q, finish_q, busy_q, underrun_q;
  logic                      accept, bit_pulse, last_bit, word_done, frame_end;
  logic                      reload, bypass, starve, move, timer_done;

  always_comb begin
    accept    = pixel_valid && ready_q;
    bit_pulse = (state_q == StShift) && new_bit_rqst;
    last_bit  = (bit_cnt_q == 5'd0);
    word_done = bit_pulse && last_bit;
    frame_end = word_done && (shifted_q == NumLeds);
    reload    = word_done && !frame_end && (hold_full_q || accept);
    // An empty holding register can still be refilled straight from the input on the reload edge.
    bypass    = reload && !hold_full_q;
    starve    = word_done && !frame_end && !reload;
    move      = (state_q == StFill) && hold_full_q;
    load_word = bypass ? pixel_data : hold_q;

    state_d = state_q;
    case (state_q)
      StIdle:  if (frame_start) state_d = StFill;
      StFill:  if (move) state_d = StShift;
      StShift: if (frame_end || starve) state_d = StLatch;
      StLatch: if (timer_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    hold_full_d = hold_full_q;
    if (move || (reload && !bypass)) hold_full_d = 1'b0;
    if (accept && !bypass) hold_full_d = 1'b1;

    accepted_d = accepted_q;
    if ((state_q == StIdle) && frame_start) begin
      accepted_d = 8'd0;
    end else if (accept) begin
      accepted_d = accepted_q + 8'd1;
    end

    ready_d = ((state_d == StFill) || (state_d == StShift)) && !hold_full_d &&
              (accepted_d != NumLeds);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= 5'd0;
      accepted_q  <= 8'd0;
      shifted_q   <= 8'd0;
      ready_q     <= 1'b0;
      latch_q     <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      accepted_q  <= accepted_d;
      ready_q     <= ready_d;
      busy_q      <= (state_d != StIdle);
      latch_q     <= (state_d == StLatch);
      finish_q    <= (state_q == StLatch) && timer_done;
      if (accept && !bypass) hold_q <= pixel_data;
      if ((state_q == StIdle) && frame_start) begin
        shifted_q  <= 8'd0;
        underrun_q <= 1'b0;
      end
      if (move || reload) begin
        shift_q   <= load_word;
        bit_cnt_q <= TopBit;
        shifted_q <= shifted_q + 8'd1;
      end else if (bit_pulse && !last_bit) begin
        shift_q   <= {shift_q[BITS_PER_PIXEL-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q - 5'd1;
      end else if (frame_end || starve) begin
        shift_q <= '0;
      end
      if (starve) underrun_q <= 1'b1;
    end
  end

  pixel_shifter_latch_timer #(
    .CYCLES(RESET_CYCLES)
  ) u_latch_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (state_q != StLatch),
    .done (timer_done)
  );

  assign pixel_ready      = ready_q;
  assign pixel_index      = accepted_q;
  assign bit_to_transmit  = shift_q[BITS_PER_PIXEL-1];
  assign all_bits_shifted = latch_q;
  assign reset_finish     = finish_q;
  assign busy             = busy_q;
  assign underrun         = underrun_q;

endmodule

// File: doc/pixel_shifter.md
PIXEL_SHIFTER -- requirements
Module: pixel_shifter

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: pixels per frame (1..255).
REQ-002 SHALL have parameter RESET_CYCLES, default 1500: latch (strip reset) low time in clk cycles (60 us at 25 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse starting a frame.
REQ-006 SHALL have port pixel_data  input  24  GRB word, G[23:16] R[15:8] B[7:0].
REQ-007 SHALL have port pixel_valid  input  1  pixel_data valid.
REQ-008 SHALL have port pixel_ready  output  1  holding register empty, word accepted when valid&&ready.
REQ-009 SHALL have port pixel_index  output  8  index of next pixel to be requested.
REQ-010 SHALL have port new_bit_rqst  input  1  one-cycle pulse from prescaler_selector: current bit finished.
REQ-011 SHALL have port bit_to_transmit  output  1  current serial bit to prescaler_selector.
REQ-012 SHALL have port all_bits_shifted  output  1  frame data done, latch period running.
REQ-013 SHALL have port reset_finish  output  1  one-cycle pulse, latch period complete.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port underrun  output  1  sticky: holding register empty when a new pixel was needed; cleared by frame_start.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, SHIFT, LATCH.
REQ-017 IDLE: frame_start -> FILL; pixel_index cleared to 0, underrun cleared; frame_start ignored in other states.
REQ-018 Holding register SHALL accept a word on pixel_valid&&pixel_ready in FILL and SHIFT; pixel_index increments on each acceptance, stops at NUM_LEDS; pixel_ready low once NUM_LEDS words accepted this frame.
REQ-019 FILL: when holding register full, next cycle SHALL move it to 24-bit shift register, bit counter = 23, bit_to_transmit = word[23], state SHIFT.
REQ-020 SHIFT: bit_to_transmit SHALL equal shift register MSB (MSB-first), stable between new_bit_rqst pulses.
REQ-021 SHIFT, new_bit_rqst with bit counter > 0: shift left one, decrement counter; new bit visible the next cycle (1-cycle latency).
REQ-022 SHIFT, new_bit_rqst with counter = 0 and more pixels pending: reload from holding register in the same edge (no gap); if holding register empty, set underrun, drive bit_to_transmit 0, go LATCH.
REQ-023 SHIFT, new_bit_rqst with counter = 0 on last pixel (NUM_LEDS words shifted): go LATCH, bit_to_transmit 0.
REQ-024 LATCH: all_bits_shifted high for entire state; latch counter counts 0..RESET_CYCLES-1; at final count reset_finish pulses for exactly one cycle, all_bits_shifted drops the same edge, state IDLE.
REQ-025 new_bit_rqst in IDLE, FILL or LATCH SHALL be ignored.
REQ-026 pixel_valid simultaneous with reload (REQ-022) SHALL be accepted: holding register written in the cycle it is emptied.
REQ-027 Bit counter 5 bits; latch counter width $clog2(RESET_CYCLES+1); pixel counters 8 bits, no wrap.

Reset
REQ-028 rstn low at a clock edge SHALL force IDLE, including mid-SHIFT or mid-LATCH; no reset_finish pulse on abort.
REQ-029 Reset values: pixel_ready 0, pixel_index 0, bit_to_transmit 0, all_bits_shifted 0, reset_finish 0, busy 0, underrun 0; shift/holding registers cleared.

Structure
REQ-030 Shared package SHALL hold FSM state encoding, BITS_PER_PIXEL = 24, default RESET_CYCLES.
REQ-031 One sub-module SHALL be natural: latch_timer (load/count/done pulse) used in LATCH.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 NUM_LEDS=1, frame_start, push 0xA50000, pulse new_bit_rqst 24x -> bit_to_transmit sequence 1,0,1,0,0,1,0,1 then 16 zeros; all_bits_shifted after 24th pulse.
REQ-034 RESET_CYCLES=10, after last bit -> all_bits_shifted high 10 cycles, reset_finish single pulse, busy low next cycle.
REQ-035 NUM_LEDS=2, second word 0xFFFFFF pushed during first pixel -> 25th bit 1 with no idle cycle; pixel_ready low after second acceptance.
REQ-036 NUM_LEDS=2, second word withheld -> underrun=1 after 24th pulse, LATCH entered; next frame_start clears underrun.
REQ-037 rstn low mid-SHIFT (bit 10 of pixel 0) -> all outputs at reset values next edge, no reset_finish.
REQ-038 new_bit_rqst pulses in IDLE and LATCH -> no change to bit_to_transmit, pixel_index or latch count.
